// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-addressed, big-endian data memory.
// Sub-word stores are done as read-modify-write of the containing word.
module mem_access_unit #(
    parameter int MEM_BYTES = 121
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] DAddr,
    output logic [31:0] DataIn,
    input  logic [31:0] Dataout,
    output logic        nRD,
    output logic        nWR
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wword_q, wword_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [2:0]  nbytes;
    logic [32:0] acc_end;
    logic        misalign;
    logic        out_of_range;
    logic        acc_err;
    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Legality of the incoming request, evaluated in IDLE only
    always_comb begin
        nbytes = 3'd0;
        unique case (size)
            SZ_B:    nbytes = 3'd1;
            SZ_H:    nbytes = 3'd2;
            SZ_W:    nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    assign misalign = (size == 2'b11)
                    || ((size == SZ_H) && addr[0])
                    || ((size == SZ_W) && (addr[1:0] != 2'b00));
    assign acc_end = {1'b0, addr} + {30'd0, nbytes};
    assign out_of_range = acc_end > 33'(MEM_BYTES);
    assign acc_err = misalign || out_of_range;

    // Big-endian: byte offset o lives at bits [31-8o -: 8]
    always_comb begin
        sh = 5'd0;
        unique case (size_q)
            SZ_B:    sh = {~addr_q[1:0], 3'b000};
            SZ_H:    sh = {~addr_q[1], 1'b0, 3'b000};
            default: sh = 5'd0;
        endcase
    end

    assign lane = Dataout >> sh;

    always_comb begin
        mask     = 32'hFFFF_FFFF;
        load_val = Dataout;
        unique case (size_q)
            SZ_B: begin
                mask     = 32'h0000_00FF << sh;
                load_val = {{24{sext_q & lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                mask     = 32'h0000_FFFF << sh;
                load_val = {{16{sext_q & lane[15]}}, lane[15:0]};
            end
            default: begin
                mask     = 32'hFFFF_FFFF;
                load_val = Dataout;
            end
        endcase
    end

    assign merged = (Dataout & ~mask) | ((wdata_q << sh) & mask);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wword_d = wword_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    err_d = acc_err;
                    if (acc_err) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr;
                        size_d  = size;
                        sext_d  = sign_ext;
                        we_d    = we;
                        wdata_d = wdata;
                        wword_d = wdata;
                        state_d = (we && size == SZ_W) ? WR : RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    wword_d = merged;
                    state_d = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = DONE;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wword_q <= wword_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign err    = done & err_q;
    assign rdata  = rdata_q;
    assign DAddr  = {addr_q[31:2], 2'b00};
    assign DataIn = wword_q;
    assign nRD    = state_q != RD;
    assign nWR    = state_q != WR;

endmodule
